ecc_op_ctrl: RTL and testbench

- APB-programmed controller that configures and sequences the shared ECC core (encoder/decoder datapath).
- Holds the operation registers (data, noise, codeword width, mode) and launches one core operation per CTRL write.
- Waits the core's fixed latency, then captures the result and error count and pulses operation_done.
- Sits between the APB bus and the ECC core at the top of the ECC subsystem.

---
 rtl/ecc_pkg.sv | 39 +++
 rtl/ecc_op_ctrl_if.sv | 49 ++++
 rtl/ecc_apb_regs.sv | 92 +++++++++
 rtl/ecc_op_ctrl.sv | 136 +++++++++++++
 tb/tb_ecc_op_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared register map, field encodings and controller states
//               for the ECC operation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

  // Register word index, i.e. byte offset >> 2 (PADDR[4:2]).
  localparam logic [2:0] c_idx_ctrl   = 3'd0;  // 0x00
  localparam logic [2:0] c_idx_data   = 3'd1;  // 0x04
  localparam logic [2:0] c_idx_width  = 3'd2;  // 0x08
  localparam logic [2:0] c_idx_noise  = 3'd3;  // 0x0C
  localparam logic [2:0] c_idx_status = 3'd4;  // 0x10

  typedef enum logic [1:0] {
    MODE_ENCODE   = 2'd0,
    MODE_DECODE   = 2'd1,
    MODE_FULL     = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    WIDTH_8        = 2'd0,
    WIDTH_16       = 2'd1,
    WIDTH_32       = 2'd2,
    WIDTH_RESERVED = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ecc_op_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ecc_op_ctrl_if
// Description : APB, ECC-core and completion signals of the ECC operation
//               controller. slave = controller side, master = bus/core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ecc_op_ctrl_if #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;

  logic [AMBA_WORD-1:0]       core_data_in;
  logic [AMBA_WORD-1:0]       core_noise;
  logic [1:0]                 core_width;
  logic [1:0]                 core_mode;
  logic                       core_start;
  logic [AMBA_WORD-1:0]       core_result;
  logic [1:0]                 core_num_err;

  logic [AMBA_WORD-1:0]       data_out;
  logic [1:0]                 num_of_errors;
  logic                       operation_done;
  logic                       busy;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA,
    output core_data_in, core_noise, core_width, core_mode, core_start,
    input  core_result, core_num_err,
    output data_out, num_of_errors, operation_done, busy
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA,
    input  core_data_in, core_noise, core_width, core_mode, core_start,
    output core_result, core_num_err,
    input  data_out, num_of_errors, operation_done, busy
  );

endinterface
`default_nettype wire

// File: rtl/ecc_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : ecc_apb_regs
// Description : APB register block: decode, storage, busy write-freeze,
//               combinational read mux, start request and illegal sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_apb_regs
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           i_addr_idx,
  input  logic                 i_psel,
  input  logic                 i_penable,
  input  logic                 i_pwrite,
  input  logic [AMBA_WORD-1:0] i_pwdata,
  input  logic                 i_busy,
  output logic [AMBA_WORD-1:0] o_prdata,
  output logic [AMBA_WORD-1:0] o_data,
  output logic [AMBA_WORD-1:0] o_noise,
  output logic [1:0]           o_width,
  output logic [1:0]           o_mode,
  output logic                 o_start
);

  logic [AMBA_WORD-1:0] r_data;
  logic [AMBA_WORD-1:0] r_noise;
  logic [1:0]           r_width;
  logic [1:0]           r_mode;
  logic                 r_illegal;

  logic w_wr;
  logic w_ctrl_wr;
  logic w_legal;

  // Writes land only while no operation is in flight, freezing core inputs.
  assign w_wr      = i_psel & i_penable & i_pwrite & ~i_busy;
  assign w_ctrl_wr = w_wr && (i_addr_idx == c_idx_ctrl);
  // Legality uses the width already held, not one written in the same cycle.
  assign w_legal   = (i_pwdata[1:0] != MODE_RESERVED) && (r_width != WIDTH_RESERVED);
  assign o_start   = w_ctrl_wr & w_legal;

  // Register storage and illegal-command tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_noise   <= '0;
      r_width   <= '0;
      r_mode    <= '0;
      r_illegal <= 1'b0;
    end else if (w_wr) begin
      case (i_addr_idx)
        c_idx_ctrl: begin
          if (w_legal) begin
            r_mode    <= i_pwdata[1:0];
            r_illegal <= 1'b0;
          end else begin
            r_illegal <= 1'b1;
          end
        end
        c_idx_data:  r_data  <= i_pwdata;
        c_idx_width: r_width <= i_pwdata[1:0];
        c_idx_noise: r_noise <= i_pwdata;
        default: ;
      endcase
    end
  end

  // Read mux; CTRL is write-only and unmapped offsets read as zero.
  always_comb begin
    o_prdata = '0;
    if (i_psel && !i_pwrite) begin
      case (i_addr_idx)
        c_idx_data:   o_prdata = r_data;
        c_idx_width:  o_prdata = {{(AMBA_WORD-2){1'b0}}, r_width};
        c_idx_noise:  o_prdata = r_noise;
        c_idx_status: o_prdata = {{(AMBA_WORD-2){1'b0}}, r_illegal, i_busy};
        default:      o_prdata = '0;
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_noise = r_noise;
  assign o_width = r_width;
  assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/ecc_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ecc_op_ctrl
// Description : APB-programmed sequencer for the ECC core. Launches one core
//               operation per legal CTRL write, waits the fixed core latency,
//               captures result and error count, pulses operation_done.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_op_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CORE_LATENCY    = 1
) (
  input  logic         clk,
  input  logic         rst,
  ecc_op_ctrl_if.slave bus
);

  localparam int             CNT_W = (CORE_LATENCY < 2) ? 1 : $clog2(CORE_LATENCY + 1);
  localparam logic [CNT_W-1:0] c_lat = CNT_W'(CORE_LATENCY);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_e               r_state;
  state_e               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [AMBA_WORD-1:0] r_data_out;
  logic [1:0]           r_num_err;

  logic                 w_busy;
  logic                 w_core_start;
  logic                 w_done;
  logic                 w_capture;
  logic                 w_start_req;
  logic [AMBA_WORD-1:0] w_data_reg;
  logic                 w_unused_paddr;

  // Only PADDR[4:2] select a register.
  assign w_unused_paddr = ^{bus.PADDR[AMBA_ADDR_WIDTH-1:5], bus.PADDR[1:0]};

  ecc_apb_regs #(
    .AMBA_WORD (AMBA_WORD)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .i_addr_idx (bus.PADDR[4:2]),
    .i_psel     (bus.PSEL),
    .i_penable  (bus.PENABLE),
    .i_pwrite   (bus.PWRITE),
    .i_pwdata   (bus.PWDATA),
    .i_busy     (w_busy),
    .o_prdata   (bus.PRDATA),
    .o_data     (w_data_reg),
    .o_noise    (bus.core_noise),
    .o_width    (bus.core_width),
    .o_mode     (bus.core_mode),
    .o_start    (w_start_req)
  );

  // The core payload may be narrower than the bus word; pad with zeros.
  generate
    if (DATA_WIDTH < AMBA_WORD) begin : g_pad_data
      logic w_unused_data_hi;
      assign w_unused_data_hi  = ^w_data_reg[AMBA_WORD-1:DATA_WIDTH];
      assign bus.core_data_in  = {{(AMBA_WORD-DATA_WIDTH){1'b0}}, w_data_reg[DATA_WIDTH-1:0]};
    end else begin : g_full_data
      assign bus.core_data_in  = w_data_reg;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next_state = r_state;
    w_core_start = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_req) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_core_start = 1'b1;
        w_busy       = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == c_one) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        // A CTRL write landing in DONE chains straight into the next launch.
        w_next_state = w_start_req ? S_ISSUE : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latency counter: loaded at launch, counts down to the capture cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (r_state == S_ISSUE) r_cnt <= c_lat;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt - c_one;
  end

  // Result capture; held until the next completed operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
      r_num_err  <= '0;
    end else if (w_capture) begin
      r_data_out <= bus.core_result;
      r_num_err  <= bus.core_num_err;
    end
  end

  assign bus.core_start     = w_core_start;
  assign bus.busy           = w_busy;
  assign bus.operation_done = w_done;
  assign bus.data_out       = r_data_out;
  assign bus.num_of_errors  = r_num_err;

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_op_ctrl
// Description : Bench for ecc_op_ctrl. Two instances (core latency 1 and 4)
//               share one APB stimulus stream; a timeline model per instance
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_op_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ecc_op_ctrl_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32)) if0 ();
  ecc_op_ctrl_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32)) if1 ();

  ecc_op_ctrl #(
    .AMBA_ADDR_WIDTH (32), .AMBA_WORD (32), .DATA_WIDTH (32), .CORE_LATENCY (1)
  ) u_dut_l1 (
    .clk (clk), .rst (rst), .bus (if0)
  );

  ecc_op_ctrl #(
    .AMBA_ADDR_WIDTH (32), .AMBA_WORD (32), .DATA_WIDTH (32), .CORE_LATENCY (4)
  ) u_dut_l4 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state per instance: register contents, held results and the
  // cycle index in which the current operation issued.
  int          lat [2] = '{1, 4};
  logic [31:0] m_data  [2];
  logic [31:0] m_noise [2];
  logic [31:0] m_dout  [2];
  logic [1:0]  m_width [2];
  logic [1:0]  m_mode  [2];
  logic [1:0]  m_nerr  [2];
  bit          m_ill   [2];
  int          m_issue [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = '0; m_noise[i] = '0; m_dout[i] = '0;
      m_width[i] = '0; m_mode[i] = '0; m_nerr[i] = '0;
      m_ill[i] = 1'b0; m_issue[i] = -1000;
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs 1 ns later,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit sel, input bit en, input bit wr, input logic [2:0] idx,
                      input logic [31:0] wdata, input bit do_rst);
    logic [31:0] res, addr, exp_rd;
    logic [1:0]  ne;
    logic [31:0] o_rd [2], o_din [2], o_noi [2], o_dout [2];
    logic [1:0]  o_wid [2], o_mod [2], o_ne [2];
    logic        o_busy [2], o_start [2], o_done [2];
    bit          b, st, dn;
    string       p;

    @(negedge clk);
    res  = $urandom;
    ne   = 2'($urandom_range(0, 2));
    addr = {27'($urandom), idx, 2'($urandom)};
    rst  = !do_rst;
    if0.PADDR = addr; if0.PSEL = sel; if0.PENABLE = en; if0.PWRITE = wr; if0.PWDATA = wdata;
    if1.PADDR = addr; if1.PSEL = sel; if1.PENABLE = en; if1.PWRITE = wr; if1.PWDATA = wdata;
    if0.core_result = res; if0.core_num_err = ne;
    if1.core_result = res; if1.core_num_err = ne;
    #1;
    if (do_rst) model_reset();

    o_rd[0] = if0.PRDATA;  o_din[0] = if0.core_data_in; o_noi[0] = if0.core_noise;
    o_dout[0] = if0.data_out; o_wid[0] = if0.core_width; o_mod[0] = if0.core_mode;
    o_ne[0] = if0.num_of_errors; o_busy[0] = if0.busy; o_start[0] = if0.core_start;
    o_done[0] = if0.operation_done;
    o_rd[1] = if1.PRDATA;  o_din[1] = if1.core_data_in; o_noi[1] = if1.core_noise;
    o_dout[1] = if1.data_out; o_wid[1] = if1.core_width; o_mod[1] = if1.core_mode;
    o_ne[1] = if1.num_of_errors; o_busy[1] = if1.busy; o_start[1] = if1.core_start;
    o_done[1] = if1.operation_done;

    for (int i = 0; i < 2; i++) begin
      b  = (cyc >= m_issue[i]) && (cyc <= m_issue[i] + lat[i]);
      st = (cyc == m_issue[i]);
      dn = (cyc == m_issue[i] + lat[i] + 1);
      exp_rd = '0;
      if (sel && !wr) begin
        case (idx)
          3'd1: exp_rd = m_data[i];
          3'd2: exp_rd = {30'd0, m_width[i]};
          3'd3: exp_rd = m_noise[i];
          3'd4: exp_rd = {30'd0, m_ill[i], b};
          default: exp_rd = '0;
        endcase
      end
      p = $sformatf("L%0d.", lat[i]);
      chk({p, "busy"},           32'(o_busy[i]),  32'(b));
      chk({p, "core_start"},     32'(o_start[i]), 32'(st));
      chk({p, "operation_done"}, 32'(o_done[i]),  32'(dn));
      chk({p, "data_out"},       o_dout[i],       m_dout[i]);
      chk({p, "num_of_errors"},  32'(o_ne[i]),    32'(m_nerr[i]));
      chk({p, "core_data_in"},   o_din[i],        m_data[i]);
      chk({p, "core_noise"},     o_noi[i],        m_noise[i]);
      chk({p, "core_width"},     32'(o_wid[i]),   32'(m_width[i]));
      chk({p, "core_mode"},      32'(o_mod[i]),   32'(m_mode[i]));
      chk({p, "PRDATA"},         o_rd[i],         exp_rd);

      if (!do_rst) begin
        if (cyc == m_issue[i] + lat[i]) begin
          m_dout[i] = res;
          m_nerr[i] = ne;
        end
        if (sel && en && wr && !b) begin
          case (idx)
            3'd0: begin
              if (wdata[1:0] != 2'd3 && m_width[i] != 2'd3) begin
                m_mode[i]  = wdata[1:0];
                m_ill[i]   = 1'b0;
                m_issue[i] = cyc + 1;
              end else begin
                m_ill[i] = 1'b1;
              end
            end
            3'd1: m_data[i]  = wdata;
            3'd2: m_width[i] = wdata[1:0];
            3'd3: m_noise[i] = wdata;
            default: ;
          endcase
        end
      end
    end
    cyc++;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b1, idx, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [2:0] idx);
    step(1'b1, 1'b1, 1'b0, idx, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  initial begin
    if0.PADDR = '0; if0.PSEL = 1'b0; if0.PENABLE = 1'b0; if0.PWRITE = 1'b0; if0.PWDATA = '0;
    if1.PADDR = '0; if1.PSEL = 1'b0; if1.PENABLE = 1'b0; if1.PWRITE = 1'b0; if1.PWDATA = '0;
    if0.core_result = '0; if0.core_num_err = '0;
    if1.core_result = '0; if1.core_num_err = '0;
    model_reset();

    // Reset state, including a STATUS read while held in reset.
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd4, 32'd0, 1'b1);
    idle(2);

    // Basic encode of an 8-bit word.
    wr_reg(3'd1, 32'hA500_0000);
    wr_reg(3'd2, 32'd0);
    wr_reg(3'd0, 32'd0);
    idle(8);

    // Reset asserted in the WAIT cycle, with STATUS being read.
    wr_reg(3'd0, 32'd1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 3'd4, 32'd0, 1'b1);
    idle(8);

    // DATA_IN write while busy is dropped.
    wr_reg(3'd1, 32'h0000_BEEF);
    wr_reg(3'd0, 32'd2);
    wr_reg(3'd1, 32'h0000_1234);
    rd_reg(3'd1);
    idle(8);

    // Illegal commands, then a legal one clears the sticky bit.
    wr_reg(3'd0, 32'd3);
    rd_reg(3'd4);
    wr_reg(3'd2, 32'd3);
    wr_reg(3'd0, 32'd0);
    rd_reg(3'd4);
    wr_reg(3'd2, 32'd2);
    wr_reg(3'd0, 32'd1);
    rd_reg(3'd4);
    idle(8);

    // CTRL write in the DONE cycle of the latency-1 instance.
    wr_reg(3'd0, 32'd0);
    idle(2);
    wr_reg(3'd0, 32'd2);
    idle(8);

    // Unmapped offset 0x14 and setup-phase-only write.
    rd_reg(3'd5);
    step(1'b1, 1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0);
    rd_reg(3'd3);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(0, 199);
      if (k < 2) begin
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
      end else begin
        step(k >= 40, k >= 55, 1'($urandom), 3'($urandom_range(0, 7)), $urandom, 1'b0);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
